// File: rtl/mp_fifo_v2_pkg.sv
// rtl/mp_fifo_v2_pkg.sv - shared width helpers and lane arithmetic for mp_fifo_v2
package mp_fifo_v2_pkg;

  function automatic int unsigned ptr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Single conditional subtract is enough because k never exceeds depth.
  function automatic int unsigned mod_add(int unsigned ptr, int unsigned k, int unsigned depth);
    int unsigned sum;
    sum = ptr + k;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

  function automatic int unsigned popcount_below(logic [31:0] vec, int unsigned i);
    int unsigned n;
    n = 0;
    for (int unsigned j = 0; j < 32; j++) begin
      if ((j < i) && vec[j]) n++;
    end
    return n;
  endfunction

  function automatic int unsigned lead_ones(logic [31:0] vec);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int unsigned j = 0; j < 32; j++) begin
      run = run & vec[j];
      if (run) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/mp_fifo_v2_ptr_ctrl.sv
// rtl/mp_fifo_v2_ptr_ctrl.sv - head/tail/used registers with modular pointer advance and flush
module mp_fifo_v2_ptr_ctrl
  import mp_fifo_v2_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [cnt_w(DEPTH)-1:0]     n_enq,
  input  logic [cnt_w(DEPTH)-1:0]     n_deq,
  input  logic                        flush,
  output logic [ptr_w(DEPTH)-1:0]     head,
  output logic [ptr_w(DEPTH)-1:0]     tail,
  output logic [cnt_w(DEPTH)-1:0]     used
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  function automatic logic [PTR_W-1:0] adv(logic [PTR_W-1:0] p, logic [CNT_W-1:0] k);
    logic [PTR_W:0] s;
    s = (PTR_W+1)'(p) + (PTR_W+1)'(k);
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      used <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      used <= '0;
    end else begin
      head <= adv(head, n_deq);
      tail <= adv(tail, n_enq);
      used <= used + n_enq - n_deq;
    end
  end

endmodule

// File: rtl/mp_fifo_v2.sv
// rtl/mp_fifo_v2.sv - multi-port in-order FIFO; MP_FIFO_V2_BYPASS_EN enables empty-queue enq->deq forwarding
module mp_fifo_v2
  import mp_fifo_v2_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH  = 32,
  parameter int unsigned ENQ_WIDTH      = 4,
  parameter int unsigned DEQ_WIDTH      = 4,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned MUST_TAKEN_ALL = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ENQ_WIDTH-1:0]               enq_vld_i,
  input  logic [ENQ_WIDTH*PAYLOAD_WIDTH-1:0] enq_payload_i,
  output logic [ENQ_WIDTH-1:0]               enq_rdy_o,
  output logic [DEQ_WIDTH-1:0]               deq_vld_o,
  output logic [DEQ_WIDTH*PAYLOAD_WIDTH-1:0] deq_payload_o,
  input  logic [DEQ_WIDTH-1:0]               deq_rdy_i,
  input  logic                               flush_i,
  output logic [$clog2(DEPTH+1)-1:0]         used_cnt_o,
  output logic                               full_o,
  output logic                               empty_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         head, tail;
  logic [CNT_W-1:0]         used, free, n_enq, n_deq, n_enq_ptr, n_deq_ptr;
  logic [ENQ_WIDTH-1:0]     enq_fire;
  logic [ENQ_WIDTH-1:0]     wr_en;
  logic [PTR_W-1:0]         wr_slot [ENQ_WIDTH];

  assign free = CNT_W'(DEPTH) - used;

  if (MUST_TAKEN_ALL != 0) begin : g_rdy_all
    assign enq_rdy_o = (free >= CNT_W'(ENQ_WIDTH)) ? {ENQ_WIDTH{1'b1}} : '0;
  end else begin : g_rdy_lane
    always_comb begin
      enq_rdy_o = '0;
      for (int unsigned i = 0; i < ENQ_WIDTH; i++) enq_rdy_o[i] = (32'(free) > i);
    end
  end

  assign enq_fire = enq_vld_i & enq_rdy_o;
  assign n_enq    = CNT_W'(popcount_below(32'(enq_fire), ENQ_WIDTH));

  always_comb begin
    deq_vld_o     = '0;
    deq_payload_o = '0;
    for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
      deq_vld_o[i] = (32'(used) > i);
      deq_payload_o[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem[PTR_W'(mod_add(32'(head), i, DEPTH))];
    end
    wr_en     = enq_fire & {ENQ_WIDTH{!flush_i}};
    n_enq_ptr = n_enq;
    for (int unsigned i = 0; i < ENQ_WIDTH; i++)
      wr_slot[i] = PTR_W'(mod_add(32'(tail), popcount_below(32'(enq_fire), i), DEPTH));
`ifdef MP_FIFO_V2_BYPASS_EN
    if ((used == '0) && !flush_i) begin
      for (int unsigned j = 0; j < DEQ_WIDTH; j++) begin
        deq_vld_o[j] = (32'(n_enq) > j);
        for (int unsigned i = 0; i < ENQ_WIDTH; i++)
          if (enq_fire[i] && (popcount_below(32'(enq_fire), i) == j))
            deq_payload_o[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = enq_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
`endif
    n_deq     = CNT_W'(lead_ones(32'(deq_vld_o & deq_rdy_i)));
    n_deq_ptr = n_deq;
`ifdef MP_FIFO_V2_BYPASS_EN
    // Entries forwarded and consumed this cycle never touch storage or pointers.
    if ((used == '0) && !flush_i) begin
      n_deq_ptr = '0;
      n_enq_ptr = n_enq - n_deq;
      for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
        wr_en[i]   = enq_fire[i] && (popcount_below(32'(enq_fire), i) >= 32'(n_deq));
        wr_slot[i] = PTR_W'(mod_add(32'(tail), popcount_below(32'(enq_fire), i) - 32'(n_deq), DEPTH));
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_WIDTH; i++)
      if (wr_en[i]) mem[wr_slot[i]] <= enq_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end

  mp_fifo_v2_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .n_enq (n_enq_ptr),
    .n_deq (n_deq_ptr),
    .flush (flush_i),
    .head  (head),
    .tail  (tail),
    .used  (used)
  );

  assign used_cnt_o = used;
  assign full_o     = (used == CNT_W'(DEPTH));
  assign empty_o    = (used == '0);

endmodule
